// File: rtl/game2048_pkg.sv
// Shared encodings and defaults for the 2048 game core.
package game2048_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    S_INIT, S_WAIT, S_SLIDE, S_WINCHK, S_SPAWN, S_LOSECHK, S_WIN, S_LOSE
  } state_e;

  // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam int          DEF_EXP_W   = 4;
  localparam int          DEF_WIN_EXP = 11;

endpackage

// File: rtl/game2048_line_merge.sv
// Combinational slide/merge of one line; element 0 sits against the destination wall.
module game2048_line_merge
  import game2048_pkg::*;
#(
  parameter int N     = 4,
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic [N-1:0][EXP_W-1:0]          line_i,
  output logic [N-1:0][EXP_W-1:0]          line_o,
  output logic                             changed_o,
  output logic [(1 << EXP_W) + $clog2(N):0] delta_o
);

  localparam int DW = (1 << EXP_W) + $clog2(N) + 1;
  localparam logic [EXP_W-1:0] EMAX = '1;

  // compress, merge each tile at most once, compress again
  always_comb begin
    logic [N-1:0][EXP_W-1:0] c;
    int k;
    c       = '0;
    line_o  = '0;
    delta_o = '0;
    k       = 0;
    for (int i = 0; i < N; i++)
      if (line_i[i] != '0) begin
        c[k] = line_i[i];
        k    = k + 1;
      end
    // a merged slot leaves a zero behind it, so the next pair cannot reuse it
    for (int i = 0; i < N - 1; i++)
      if (c[i] != '0 && c[i] == c[i+1] && c[i] != EMAX) begin
        c[i]    = c[i] + 1'b1;
        c[i+1]  = '0;
        delta_o = delta_o + (DW'(1) << c[i]);
      end
    k = 0;
    for (int i = 0; i < N; i++)
      if (c[i] != '0) begin
        line_o[k] = c[i];
        k         = k + 1;
      end
  end

  assign changed_o = (line_o != line_i);

endmodule

// File: rtl/game2048_engine.sv
// 2048 core: board storage, line-serial moves, LFSR spawns, score and win/lose tracking.
module game2048_engine
  import game2048_pkg::*;
#(
  parameter int          N       = 4,
  parameter int          EXP_W   = DEF_EXP_W,
  parameter int          WIN_EXP = DEF_WIN_EXP,
  parameter int          SCORE_W = 32,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  new_game,
  input  logic                  move_valid,
  input  logic [1:0]            move_dir,
  output logic                  move_ready,
  input  logic                  ld_en,
  input  logic [$clog2(N)-1:0]  ld_row,
  input  logic [$clog2(N)-1:0]  ld_col,
  input  logic [EXP_W-1:0]      ld_exp,
  input  logic [$clog2(N)-1:0]  rd_row,
  input  logic [$clog2(N)-1:0]  rd_col,
  output logic [EXP_W-1:0]      rd_exp,
  output logic [SCORE_W-1:0]    score,
  output logic                  win,
  output logic                  lose
);

  localparam int IW = $clog2(N);
  localparam int NN = N * N;
  localparam int FW = $clog2(NN);
  localparam int DW = (1 << EXP_W) + IW + 1;

  state_e                          state_q, state_d;
  logic [N-1:0][N-1:0][EXP_W-1:0]  board_q;
  logic [15:0]                     lfsr_q;
  logic [SCORE_W-1:0]              score_q;
  logic                            win_q, lose_q;
  logic                            changed_q;
  logic                            spawn2_q, spawn2_d;
  dir_e                            dir_q;
  logic [IW-1:0]                   line_q;
  logic [FW-1:0]                   idx_q, idx_d, sp_start, idx_inc;
  logic [IW-1:0]                   sp_row, sp_col;
  logic                            sp_empty, any_win, can_move, last_line;
  logic [N-1:0][EXP_W-1:0]         line_in, line_out;
  logic                            line_chg;
  logic [DW-1:0]                   line_delta;

  game2048_line_merge #(.N(N), .EXP_W(EXP_W)) u_merge (
    .line_i    (line_in),
    .line_o    (line_out),
    .changed_o (line_chg),
    .delta_o   (line_delta)
  );

  assign last_line = (int'(line_q) == N - 1);
  assign sp_start  = FW'(int'(lfsr_q[2*IW-1:0]) % NN);
  assign idx_inc   = (int'(idx_q) == NN - 1) ? '0 : idx_q + 1'b1;
  assign sp_row    = IW'(int'(idx_q) / N);
  assign sp_col    = IW'(int'(idx_q) % N);
  assign sp_empty  = (board_q[sp_row][sp_col] == '0);

  // gather the current line, element 0 nearest the destination wall
  always_comb begin
    line_in = '0;
    for (int e = 0; e < N; e++)
      case (dir_q)
        DIR_LEFT:  line_in[e] = board_q[line_q][e];
        DIR_RIGHT: line_in[e] = board_q[line_q][N-1-e];
        DIR_UP:    line_in[e] = board_q[e][line_q];
        default:   line_in[e] = board_q[N-1-e][line_q];
      endcase
  end

  // whole-board scans for the win and lose checks
  always_comb begin
    any_win  = 1'b0;
    can_move = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (int'(board_q[r][c]) >= WIN_EXP) any_win  = 1'b1;
        if (board_q[r][c] == '0)            can_move = 1'b1;
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N - 1; c++)
        if (board_q[r][c] == board_q[r][c+1]) can_move = 1'b1;
    for (int r = 0; r < N - 1; r++)
      for (int c = 0; c < N; c++)
        if (board_q[r][c] == board_q[r+1][c]) can_move = 1'b1;
  end

  // next state, spawn scan index and second-spawn flag
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    spawn2_d = spawn2_q;
    case (state_q)
      S_INIT: begin
        state_d  = S_SPAWN;
        idx_d    = sp_start;
        spawn2_d = 1'b1;
      end
      S_WAIT:    if (move_valid) state_d = S_SLIDE;
      S_SLIDE:   if (last_line) state_d = (changed_q | line_chg) ? S_WINCHK : S_WAIT;
      S_WINCHK:
        if (any_win) state_d = S_WIN;
        else begin
          state_d = S_SPAWN;
          idx_d   = sp_start;
        end
      S_SPAWN:
        if (sp_empty) begin
          // the INIT path spawns twice; the second scan restarts from a fresh LFSR index
          if (spawn2_q) begin
            spawn2_d = 1'b0;
            idx_d    = sp_start;
          end else begin
            state_d = S_LOSECHK;
          end
        end else begin
          idx_d = idx_inc;
        end
      S_LOSECHK: state_d = can_move ? S_WAIT : S_LOSE;
      default: ;
    endcase
    if (new_game) state_d = S_INIT;
  end

  // control registers and free-running LFSR
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_INIT;
      lfsr_q    <= SEED;
      idx_q     <= '0;
      spawn2_q  <= 1'b0;
      dir_q     <= DIR_UP;
      line_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      idx_q    <= idx_d;
      spawn2_q <= spawn2_d;
      if (state_q == S_WAIT && move_valid) begin
        dir_q     <= dir_e'(move_dir);
        line_q    <= '0;
        changed_q <= 1'b0;
      end else if (state_q == S_SLIDE) begin
        line_q    <= line_q + 1'b1;
        changed_q <= changed_q | line_chg;
      end
    end
  end

  // board contents, score and sticky flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      board_q <= '0;
      score_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else if (new_game) begin
      score_q <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          board_q <= '0;
          score_q <= '0;
        end
        S_WAIT: if (ld_en) board_q[ld_row][ld_col] <= ld_exp;
        S_SLIDE: begin
          score_q <= score_q + SCORE_W'(line_delta);
          for (int e = 0; e < N; e++)
            case (dir_q)
              DIR_LEFT:  board_q[line_q][e]     <= line_out[e];
              DIR_RIGHT: board_q[line_q][N-1-e] <= line_out[e];
              DIR_UP:    board_q[e][line_q]     <= line_out[e];
              default:   board_q[N-1-e][line_q] <= line_out[e];
            endcase
        end
        S_WINCHK:  if (any_win) win_q <= 1'b1;
        S_SPAWN:
          if (sp_empty)
            board_q[sp_row][sp_col] <= (lfsr_q[2:0] == 3'd0) ? EXP_W'(2) : EXP_W'(1);
        S_LOSECHK: if (!can_move) lose_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign move_ready = (state_q == S_WAIT);
  assign rd_exp     = board_q[rd_row][rd_col];
  assign score      = score_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_game2048_engine.sv
// Directed bench for game2048_engine (N=4) with hand-computed expectations.
module tb_game2048_engine;
  import game2048_pkg::*;

  logic        Clk = 1'b0, Reset_n = 1'b0, new_game = 1'b0;
  logic        move_valid = 1'b0, ld_en = 1'b0;
  logic [1:0]  move_dir = '0, ld_row = '0, ld_col = '0, rd_row = '0, rd_col = '0;
  logic [3:0]  ld_exp = '0, rd_exp;
  logic        move_ready, win, lose;
  logic [31:0] score;

  int          n_chk = 0, n_fail = 0;
  int          cyc;
  logic [3:0]  brd [4][4];
  logic [3:0]  lb  [4][4];

  game2048_engine #(.N(4), .EXP_W(4), .WIN_EXP(11), .SCORE_W(32), .SEED(16'hACE1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .new_game(new_game),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .ld_en(ld_en), .ld_row(ld_row), .ld_col(ld_col), .ld_exp(ld_exp),
    .rd_row(rd_row), .rd_col(rd_col), .rd_exp(rd_exp),
    .score(score), .win(win), .lose(lose)
  );

  always #50 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // snapshot the board through the display port (16 short steps within a half period)
  task automatic read_board();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rd_row = 2'(r); rd_col = 2'(c);
        #1;
        brd[r][c] = rd_exp;
      end
  endtask

  function automatic int count_nz();
    int n = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (brd[r][c] != 4'd0) n++;
    return n;
  endfunction

  function automatic int count_bad();
    int n = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (brd[r][c] > 4'd2) n++;
    return n;
  endfunction

  task automatic clear_lb();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) lb[r][c] = 4'd0;
  endtask

  task automatic set_row0(input logic [3:0] a, b, c, d);
    lb[0][0] = a; lb[0][1] = b; lb[0][2] = c; lb[0][3] = d;
  endtask

  task automatic load_board();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ld_en = 1'b1; ld_row = 2'(r); ld_col = 2'(c); ld_exp = lb[r][c];
        @(negedge Clk);
      end
    ld_en = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!move_ready && n < 100) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // n counts negedges from the accepting edge until ready/win/lose
  task automatic do_move(input logic [1:0] d, output int n);
    move_dir = d; move_valid = 1'b1;
    @(negedge Clk);
    move_valid = 1'b0;
    n = 1;
    while (!move_ready && !win && !lose && n < 200) begin
      @(negedge Clk);
      n++;
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge Clk);
    chk("rst_ready", move_ready, 0);
    chk("rst_score", score, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    read_board();
    chk("rst_tiles", count_nz(), 0);

    // power-up: INIT, two spawns, LOSECHK
    Reset_n = 1'b1;
    wait_ready(cyc);
    chk("init_ready_35", cyc <= 35, 1);
    read_board();
    chk("init_tiles", count_nz(), 2);
    chk("init_vals", count_bad(), 0);
    chk("init_score", score, 0);
    chk("init_flags", {win, lose}, 0);

    // [1,1,1,1] LEFT -> [2,2,0,0], +8, one spawn
    clear_lb(); set_row0(1, 1, 1, 1); load_board();
    do_move(DIR_LEFT, cyc);
    chk("m1_done", move_ready, 1);
    read_board();
    chk("m1_c00", brd[0][0], 2);
    chk("m1_c01", brd[0][1], 2);
    chk("m1_score", score, 8);
    chk("m1_tiles", count_nz(), 3);
    chk("m1_vals", (brd[0][2] <= 2 && brd[0][3] <= 2), 1);
    do_move(DIR_LEFT, cyc);
    read_board();
    chk("m2_c00", brd[0][0], 3);
    chk("m2_score", score, 16);

    // [2,0,2,1] RIGHT -> [0,0,3,1], +8
    clear_lb(); set_row0(2, 0, 2, 1); load_board();
    do_move(DIR_RIGHT, cyc);
    chk("m3_done", move_ready, 1);
    read_board();
    chk("m3_c02", brd[0][2], 3);
    chk("m3_c03", brd[0][3], 1);
    chk("m3_score", score, 24);
    chk("m3_tiles", count_nz(), 3);

    // [1,2,3,4] LEFT -> unchanged, no spawn, N+1 cycles
    clear_lb(); set_row0(1, 2, 3, 4); load_board();
    do_move(DIR_LEFT, cyc);
    chk("m4_cycles", cyc, 5);
    read_board();
    chk("m4_row0", {brd[0][0], brd[0][1], brd[0][2], brd[0][3]}, 16'h1234);
    chk("m4_tiles", count_nz(), 4);
    chk("m4_score", score, 24);

    // [10,10,0,0] LEFT -> 11 wins
    clear_lb(); set_row0(10, 10, 0, 0); load_board();
    do_move(DIR_LEFT, cyc);
    chk("m5_win", win, 1);
    read_board();
    chk("m5_c00", brd[0][0], 11);
    chk("m5_score", score, 24 + 2048);
    repeat (3) @(negedge Clk);
    chk("m5_ready_held", move_ready, 0);
    chk("m5_win_sticky", win, 1);
    new_game = 1'b1;
    @(negedge Clk);
    new_game = 1'b0;
    chk("ng_win", win, 0);
    chk("ng_score", score, 0);
    wait_ready(cyc);
    chk("ng_ready_35", cyc <= 35, 1);
    read_board();
    chk("ng_tiles", count_nz(), 2);

    // checkerboard of 3/4 with row0=[3,4,3,0] RIGHT -> [s,3,4,3], lose
    for (int r = 1; r < 4; r++)
      for (int c = 0; c < 4; c++) lb[r][c] = ((r + c) % 2 == 1) ? 4'd3 : 4'd4;
    set_row0(3, 4, 3, 0); load_board();
    do_move(DIR_RIGHT, cyc);
    chk("m6_lose", lose, 1);
    chk("m6_ready", move_ready, 0);
    read_board();
    chk("m6_row0", {brd[0][1], brd[0][2], brd[0][3]}, 12'h343);
    chk("m6_spawn", (brd[0][0] == 4'd1 || brd[0][0] == 4'd2), 1);
    chk("m6_score", score, 0);

    // async reset in the middle of a spawn
    new_game = 1'b1;
    @(negedge Clk);
    new_game = 1'b0;
    chk("ng2_lose", lose, 0);
    wait_ready(cyc);
    clear_lb(); set_row0(1, 1, 0, 0); load_board();
    move_dir = DIR_LEFT; move_valid = 1'b1;
    @(negedge Clk);
    move_valid = 1'b0;
    repeat (5) @(negedge Clk);
    rd_row = 2'd0; rd_col = 2'd0;
    #1;
    chk("sp_score", score, 4);
    chk("sp_c00", rd_exp, 2);
    chk("sp_ready", move_ready, 0);
    Reset_n = 1'b0;
    #1;
    chk("ar_score", score, 0);
    chk("ar_c00", rd_exp, 0);
    chk("ar_ready", move_ready, 0);
    chk("ar_flags", {win, lose}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game2048_engine.md
# game2048_engine

Parametrised 2048 game core: holds an N×N board of log-encoded tiles and executes slide/merge moves one line per cycle. Spawns new tiles from an internal LFSR, only after moves that change the board. Tracks score and detects win and lose. Sits between the debounced direction-button logic and the VGA tile renderer, which reads cells through a combinational read port.

## Interface
- N, 4: board dimension (N×N); N ≥ 2
- EXP_W, 4: tile exponent width; 0 = empty, k = tile value 2^k
- WIN_EXP, 11: exponent that wins (2048)
- SCORE_W, 32: score width, wraps modulo 2^SCORE_W
- SEED, 16'hACE1: LFSR reset value; must be nonzero
- Clk  in  1  clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- new_game  in  1  restart from any state; clears board and score
- move_valid  in  1  move request
- move_dir  in  2  0=UP, 1=DOWN, 2=LEFT, 3=RIGHT
- move_ready  out  1  high only in WAIT; a move is accepted on move_valid & move_ready
- ld_en, ld_row, ld_col, ld_exp  in  1, clog2(N), clog2(N), EXP_W  cell write; honoured only in WAIT; ignored elsewhere
- rd_row, rd_col  in  clog2(N) each  display read address
- rd_exp  out  EXP_W  combinational board[rd_row][rd_col]
- score  out  SCORE_W  accumulated score
- win, lose  out  1  sticky status flags

## Operation
- States:
  - INIT: clear board and score, then go to SPAWN twice.
  - WAIT: accepts loads and moves.
  - SLIDE: processes N cycles, one line per cycle.
  - WINCHK → SPAWN → LOSECHK → WAIT.
  - WIN and LOSE are terminal until new_game or reset.
- Line extraction, element 0 nearest the destination wall:
  - LEFT: row i, cols 0..N-1. RIGHT: row i reversed.
  - UP: column i, rows 0..N-1. DOWN: column i reversed.
  - Results are written back to the same positions.
- Line merge, per 2048 rules:
  - Compress non-zero tiles toward element 0.
  - Scan pairs from element 0: equal non-zero neighbours merge to exp+1, and the second becomes 0. A tile merges at most once per move, so [1,1,1,1] → [2,2,0,0], not [3,0,0,0].
  - Compress again.
  - A pair whose exponent is 2^EXP_W−1 does not merge.
- Score: each merge producing exponent e adds 2^e. All merges within a line are added in the same cycle.
- changed flag: OR over lines of (output ≠ input).
  - After the last SLIDE cycle, if changed=0, return to WAIT with no spawn.
- WINCHK: any cell ≥ WIN_EXP → WIN, set win; otherwise → SPAWN.
- SPAWN:
  - Start index = LFSR[2·clog2(N)−1:0] mod N·N.
  - Scan one cell per cycle, row-major with wrap-around, until the first empty cell.
  - Write exp 2 if LFSR[2:0]==0 at write time, else exp 1.
  - After a changed move at least one empty cell exists, so the scan always terminates.
- LOSECHK:
  - No empty cell and no horizontally or vertically adjacent equal pair → LOSE, set lose.
  - Otherwise → WAIT.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle out of reset.
- new_game:
  - Overrides a simultaneous move or load, in any state including mid-SLIDE and mid-SPAWN.
  - Next state is INIT, clears win, lose and score; the LFSR is not reseeded.
- Loads in WAIT write the cell directly. No win or lose check runs after a load.

## Timing
- Reset values: board all 0, score 0, win 0, lose 0, move_ready 0, state INIT, LFSR = SEED.
- After Reset_n rises, INIT takes 1 cycle, then two spawns, then LOSECHK, then WAIT.
  - move_ready rises within 2 + 2·N·N + 1 cycles.
- Accepted move, no change: move_ready low for N+1 cycles (SLIDE ×N, then WAIT).
- Accepted move, changed: N SLIDE + 1 WINCHK + 1..N·N SPAWN + 1 LOSECHK cycles.
- score, win and lose update on the edge that leaves the respective state.
- rd_exp has no latency. During SLIDE it may show partially updated lines.

## Structure
- Package game2048_pkg holds:
  - direction encoding (UP/DOWN/LEFT/RIGHT)
  - state enum
  - LFSR taps
  - default EXP_W and WIN_EXP
- Sub-module game2048_line_merge (parameters N, EXP_W), purely combinational:
  - inputs: line
  - outputs: merged line, changed, score delta
  - one instance, time-multiplexed over lines.

## Test plan
- Reset, N=4: move_ready within 35 cycles; exactly two non-zero cells, each exp 1 or 2; score=0; win=lose=0.
- Load row0=[1,1,1,1], others empty; LEFT → row0=[2,2,0,0], score=8, exactly one new tile. Second LEFT → row0 starts with [3,...], score=16.
- Load row0=[2,0,2,1], others empty; RIGHT → row0=[0,0,3,1], score +8.
- Load row0=[1,2,3,4], others empty; LEFT → no change, move_ready returns after 5 cycles, tile count and score unchanged.
- Load row0=[10,10,0,0]; LEFT → cell(0,0)=11, win=1, move_ready stays 0; new_game → board reinitialised, win=0.
- Load rows 1–3 with cell=3 if (i+j) odd, else 4; row0=[3,4,3,0]; RIGHT → row0=[s,3,4,3] with s∈{1,2}, lose=1. Assert Reset_n low mid-SPAWN → all outputs return to reset values immediately.
